// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the core data-memory bridge: access-size codes,
// bridge FSM states and the captured request attributes.
package dmem_bridge_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    // Request attributes kept for the whole transaction; address and write
    // data are held separately because their widths are parameters.
    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       uns;
        logic [1:0] off;
    } cap_t;

    // Reserved size, or an access that straddles its natural alignment.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_RSVD) ||
               (size == SZ_HALF && off[0]) ||
               (size == SZ_WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering: strobe generation and write-data replication for stores,
// lane extraction and sign/zero extension for loads. Purely combinational.
module dmem_lane
    import dmem_bridge_pkg::*;
(
    input  logic [1:0]  wr_size,
    input  logic [1:0]  wr_off,
    input  logic [31:0] wr_data,
    output logic [3:0]  wr_strobe,
    output logic [31:0] wr_lanes,
    input  logic [1:0]  rd_size,
    input  logic [1:0]  rd_off,
    input  logic        rd_uns,
    input  logic [31:0] rd_raw,
    output logic [31:0] rd_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Store side: enable the addressed lanes, replicate data onto every lane.
    always_comb begin
        wr_strobe = 4'b1111;
        wr_lanes  = wr_data;
        case (wr_size)
            SZ_BYTE: begin
                wr_strobe = 4'b0001 << wr_off;
                wr_lanes  = {4{wr_data[7:0]}};
            end
            SZ_HALF: begin
                wr_strobe = 4'b0011 << wr_off;
                wr_lanes  = {2{wr_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed lane(s) and extend to a full word.
    always_comb begin
        rd_byte = rd_raw[{rd_off, 3'b000} +: 8];
        rd_half = rd_raw[{rd_off[1], 4'b0000} +: 16];
        case (rd_size)
            SZ_BYTE: rd_data = {{24{~rd_uns & rd_byte[7]}}, rd_byte};
            SZ_HALF: rd_data = {{16{~rd_uns & rd_half[15]}}, rd_half};
            default: rd_data = rd_raw;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// Single-outstanding bridge from the core's memory stage to a handshaked
// data bus. Aligns/strobes stores, extracts/extends loads, flags misaligned
// or reserved-size accesses and bus timeouts on the completion pulse.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              creq_valid,
    output logic              creq_ready,
    input  logic [ADDR_W-1:0] creq_addr,
    input  logic              creq_we,
    input  logic [1:0]        creq_size,
    input  logic              creq_unsigned,
    input  logic [DATA_W-1:0] creq_wdata,
    output logic              cresp_valid,
    output logic              cresp_err,
    output logic [DATA_W-1:0] cresp_rdata,
    output logic              mreq_valid,
    input  logic              mreq_ready,
    output logic [ADDR_W-1:0] mreq_addr,
    output logic              mreq_we,
    output logic [3:0]        mreq_strobe,
    output logic [DATA_W-1:0] mreq_wdata,
    input  logic              mresp_valid,
    input  logic [DATA_W-1:0] mresp_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    cap_t              cap;
    logic [ADDR_W-3:0] word_addr;

    logic [3:0]        lane_strobe;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_rdata;
    logic              last_cycle;

    dmem_lane u_lane (
        .wr_size   (creq_size),
        .wr_off    (creq_addr[1:0]),
        .wr_data   (creq_wdata),
        .wr_strobe (lane_strobe),
        .wr_lanes  (lane_wdata),
        .rd_size   (cap.size),
        .rd_off    (cap.off),
        .rd_uns    (cap.uns),
        .rd_raw    (mresp_rdata),
        .rd_data   (lane_rdata)
    );

    assign creq_ready  = (state == IDLE);
    assign mreq_valid  = (state == REQ);
    assign cresp_valid = (state == DONE);
    assign mreq_addr   = {word_addr, 2'b00};
    assign mreq_we     = cap.we;
    // Counter would hit TIMEOUT on this edge; a completion this cycle still wins.
    assign last_cycle  = (cnt == CNT_LAST);

    // Transaction FSM with request capture, timeout counter and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            cap         <= '0;
            word_addr   <= '0;
            mreq_strobe <= '0;
            mreq_wdata  <= '0;
            cresp_err   <= 1'b0;
            cresp_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (creq_valid) begin
                        cap         <= '{we: creq_we, size: creq_size,
                                         uns: creq_unsigned, off: creq_addr[1:0]};
                        word_addr   <= creq_addr[ADDR_W-1:2];
                        mreq_strobe <= lane_strobe;
                        mreq_wdata  <= lane_wdata;
                        cnt         <= '0;
                        if (misaligned(creq_size, creq_addr[1:0])) begin
                            state       <= DONE;
                            cresp_err   <= 1'b1;
                            cresp_rdata <= '0;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    cnt <= cnt + 1'b1;
                    if (mreq_ready && mresp_valid) begin
                        state       <= DONE;
                        cresp_err   <= 1'b0;
                        cresp_rdata <= cap.we ? '0 : lane_rdata;
                    end else if (last_cycle) begin
                        state       <= DONE;
                        cresp_err   <= 1'b1;
                        cresp_rdata <= '0;
                    end else if (mreq_ready) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    cnt <= cnt + 1'b1;
                    if (mresp_valid) begin
                        state       <= DONE;
                        cresp_err   <= 1'b0;
                        cresp_rdata <= cap.we ? '0 : lane_rdata;
                    end else if (last_cycle) begin
                        state       <= DONE;
                        cresp_err   <= 1'b1;
                        cresp_rdata <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits between the multi-cycle core's data-memory port and a handshaked data bus.
- Takes one load/store request at a time from the core's memory stage.
- Generates byte strobes and lane-aligned write data, then runs the bus transaction.
- Returns aligned, extended read data with a done/error pulse; the core FSM stalls its memory stage until that pulse.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (4 byte lanes, fixed).
- TIMEOUT, 255, bus cycles allowed per transaction before an error is forced.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- creq_valid  in  1  core request; held stable until cresp_valid.
- creq_ready  out  1  bridge can accept (state IDLE).
- creq_addr  in  ADDR_W  byte address.
- creq_we  in  1  1=store, 0=load.
- creq_size  in  2  0=byte, 1=half, 2=word, 3=reserved.
- creq_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- creq_wdata  in  DATA_W  store data, right-justified.
- cresp_valid  out  1  one-cycle completion pulse.
- cresp_err  out  1  valid with cresp_valid: misaligned, reserved size, or timeout.
- cresp_rdata  out  DATA_W  extended load data, valid with cresp_valid.
- mreq_valid  out  1  bus request.
- mreq_ready  in  1  bus accepts request.
- mreq_addr  out  ADDR_W  word-aligned address (low 2 bits 0).
- mreq_we  out  1  write.
- mreq_strobe  out  4  byte-lane enables.
- mreq_wdata  out  DATA_W  lane-replicated write data.
- mresp_valid  in  1  bus completion; carries read data for loads.
- mresp_rdata  in  DATA_W  raw bus word.

Behaviour:
- Reset values (any time reset=0, asynchronously):
  - State IDLE; timeout counter 0.
  - mreq_valid=0, cresp_valid=0, cresp_err=0, cresp_rdata=0, creq_ready=1.
  - Captured request registers cleared.
- A reset in mid-transaction abandons the transaction. Any later mresp_valid arriving in IDLE is ignored.
- Acceptance:
  - In IDLE, creq_valid=1 captures addr, we, size, unsigned and wdata on the clock edge.
  - creq_ready=0 in every state other than IDLE.
- Alignment check, done at capture:
  - Error if size=3, or size=1 with addr[0]=1, or size=2 with addr[1:0]!=0.
  - On error: go to DONE with err=1 and rdata=0. No bus request is ever raised.
- Strobe and data generation, registered at capture, with o = addr[1:0]:
  - Byte: strobe 4'b0001<<o; wdata = {4{wdata[7:0]}}.
  - Half: strobe 4'b0011<<o; wdata = {2{wdata[15:0]}}.
  - Word: strobe 4'b1111; wdata unchanged.
  - mreq_strobe=0 is never driven while mreq_valid=1.
- States:
  - IDLE → REQ on a legal capture; IDLE → DONE on an illegal capture.
  - REQ: mreq_valid=1; addr/we/strobe/wdata stay stable until mreq_ready.
    - mreq_ready=1 → RESP.
    - mreq_ready=1 and mresp_valid=1 in the same cycle → DONE directly, using that data.
  - RESP: waits for mresp_valid → DONE.
  - DONE: cresp_valid=1 for exactly one cycle → IDLE.
- Latency:
  - Minimum accept-to-cresp_valid is 2 cycles (capture, REQ with same-cycle ready+resp, then DONE).
  - An illegal request completes 1 cycle after capture.
- Timeout:
  - The counter increments each cycle in REQ or RESP and resets on entry to REQ.
  - When it reaches TIMEOUT with no completion: go to DONE with err=1 and rdata=0, drop mreq_valid.
  - A completion in the same cycle as the counter reaching TIMEOUT takes priority (err=0).
- Load data:
  - Select byte mresp_rdata[8*o +: 8] or half mresp_rdata[16*o[1] +: 16].
  - Extend to DATA_W per creq_unsigned; word passes through unchanged.
  - cresp_rdata is registered and holds its value until the next DONE.
- Stores complete on mresp_valid exactly like loads, with cresp_rdata=0.
- mresp_valid outside REQ/RESP is ignored.

Decomposition:
- Shared package: size encoding constants (SZ_BYTE/SZ_HALF/SZ_WORD), bridge state enum (IDLE/REQ/RESP/DONE), and a struct for the captured request.
- One natural sub-module, dmem_lane: a combinational strobe/write-data replicate plus read-data extract/extend unit, shared by both directions.

Test Plan:
- Word load addr=0x100, bus ready after 2 cycles, rdata=0xDEADBEEF → mreq_strobe=1111, mreq_addr=0x100, cresp_rdata=0xDEADBEEF, err=0.
- Signed byte load addr=0x103, bus rdata=0x80FFFFFF → cresp_rdata=0xFFFFFF80; the same load with unsigned=1 → 0x00000080.
- Half store addr=0x202, wdata=0x1234ABCD → mreq_addr=0x200, strobe=1100, mreq_wdata=0xABCDABCD; cresp_valid after mresp_valid.
- Word load addr=0x101 → no mreq_valid ever; cresp_valid=1 and err=1 exactly 1 cycle after accept.
- TIMEOUT=4, mreq_ready held at 0 → cresp_err=1 on the 5th cycle after accept; then a new request is accepted normally.
- Reset pulled low while in RESP, then mresp_valid arrives after release → outputs go to reset values immediately; the stray response produces no cresp_valid.
